shamt_extract: RTL and testbench

Shift-amount extraction unit for the EXE stage of the 5-stage MIPS pipeline.
- Takes the sign-extended immediate and the rs operand.
- Produces the zero-extended shift amount: the instruction shamt field (bits [10:6] of the extended immediate) for sll/srl/sra, or rs[4:0] for variable shifts.
- Provides a combinational result for same-cycle ALU operand muxing and a registered copy with valid, stall and flush control for the next stage.

---
 rtl/shamt_extract.sv | 50 +++++
 tb/tb_shamt_extract.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shamt_extract.sv
// Shift-amount extraction for the EXE stage: selects the instruction shamt field
// or rs[4:0], zero-extends it, and offers both a combinational and a registered copy.
module shamt_extract #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int SHAMT_LSB   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] imme_after_extension,
  input  logic [DATA_WIDTH-1:0] rs_value,
  input  logic                  src_sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0] shamt_q,
  output logic                  shamt_zero_q,
  output logic                  out_valid
);

  logic [SHAMT_WIDTH-1:0] field;
  logic                   unused_inputs;

  // Only the selected field matters; the rest of both buses is intentionally ignored.
  assign unused_inputs = ^{imme_after_extension, rs_value};

  assign field = src_sel ? rs_value[SHAMT_WIDTH-1:0]
                         : imme_after_extension[SHAMT_LSB+SHAMT_WIDTH-1:SHAMT_LSB];

  // Zero-extend so the immediate's sign bits never leak into the shift amount.
  assign shamt = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, field};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shamt_q      <= '0;
      shamt_zero_q <= 1'b1;
      out_valid    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      shamt_q      <= shamt;
      shamt_zero_q <= (shamt == '0);
      out_valid    <= in_valid;
    end
  end

endmodule

// File: tb/tb_shamt_extract.sv
// Directed bench for shamt_extract: a reference model pushes expected registered
// outputs into a scoreboard queue that is popped after each clock edge.
module tb_shamt_extract;

  localparam int DW  = 32;
  localparam int SW  = 5;
  localparam int LSB = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] imme_after_extension;
  logic [DW-1:0] rs_value;
  logic          src_sel;
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic [DW-1:0] shamt;
  logic [DW-1:0] shamt_q;
  logic          shamt_zero_q;
  logic          out_valid;

  typedef struct {
    logic [DW-1:0] q;
    logic          z;
    logic          v;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_q;
  logic          m_z;
  logic          m_v;
  int            n_tests = 0;
  int            n_fail  = 0;

  shamt_extract #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .SHAMT_LSB(LSB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .imme_after_extension (imme_after_extension),
    .rs_value             (rs_value),
    .src_sel              (src_sel),
    .in_valid             (in_valid),
    .stall                (stall),
    .flush                (flush),
    .shamt                (shamt),
    .shamt_q              (shamt_q),
    .shamt_zero_q         (shamt_zero_q),
    .out_valid            (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_shamt(input logic sel, input logic [DW-1:0] imm,
                                              input logic [DW-1:0] rs);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++)
      r[i] = sel ? rs[i] : imm[LSB+i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input exp_t e);
    check({tag, "/shamt_q"}, shamt_q, e.q);
    check({tag, "/zero_q"}, {{(DW-1){1'b0}}, shamt_zero_q}, {{(DW-1){1'b0}}, e.z});
    check({tag, "/out_valid"}, {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, e.v});
  endtask

  // One cycle: drive inputs, check the combinational result, predict the
  // registered state, then compare it after the next rising edge.
  task automatic step(input string tag, input logic v, input logic sel,
                      input logic [DW-1:0] imm, input logic [DW-1:0] rs,
                      input logic st, input logic fl);
    logic [DW-1:0] e;
    exp_t          x;
    in_valid = v; src_sel = sel; imme_after_extension = imm; rs_value = rs;
    stall = st; flush = fl;
    #1;
    e = ref_shamt(sel, imm, rs);
    check({tag, "/comb"}, shamt, e);
    if (fl) m_v = 1'b0;
    else if (!st) begin
      m_q = e; m_z = (e == '0); m_v = v;
    end
    x.q = m_q; x.z = m_z; x.v = m_v;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s/scoreboard observed=empty expected=entry", tag);
    end else begin
      x = sb_q.pop_front();
      check_regs(tag, x);
    end
  endtask

  task automatic model_reset();
    exp_t r;
    m_q = '0; m_z = 1'b1; m_v = 1'b0;
    sb_q.delete();
    r.q = m_q; r.z = m_z; r.v = m_v;
    check_regs("reset", r);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; src_sel = 1'b0; stall = 1'b0; flush = 1'b0;
    imme_after_extension = '0; rs_value = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Immediate field extraction, including sign-extended immediates.
    step("imm_7c0", 1'b1, 1'b0, 32'h0000_07C0, 32'h0, 1'b0, 1'b0);
    check("imm_7c0/val", shamt_q, 32'h0000_001F);
    step("imm_040", 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("imm_040/val", shamt_q, 32'h0000_0001);
    step("imm_neg", 1'b1, 1'b0, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0);
    check("imm_neg/val", shamt_q, 32'h0000_001E);
    step("imm_03f", 1'b1, 1'b0, 32'h0000_003F, 32'h1F, 1'b0, 1'b0);
    check("imm_03f/zero", {31'b0, shamt_zero_q}, 32'h1);

    // Register source.
    step("rs_23", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF23, 1'b0, 1'b0);
    check("rs_23/val", shamt_q, 32'h0000_0003);
    step("rs_20", 1'b1, 1'b1, 32'h0000_07C0, 32'h0000_0020, 1'b0, 1'b0);
    check("rs_20/zero", {31'b0, shamt_zero_q}, 32'h1);

    // Back-to-back pipelining, then an invalid slot that still updates shamt_q.
    step("pipe_5", 1'b1, 1'b1, 32'h0, 32'd5, 1'b0, 1'b0);
    step("pipe_9", 1'b1, 1'b1, 32'h0, 32'd9, 1'b0, 1'b0);
    step("pipe_31", 1'b1, 1'b1, 32'h0, 32'd31, 1'b0, 1'b0);
    check("pipe_31/val", shamt_q, 32'd31);
    step("invalid", 1'b0, 1'b1, 32'h0, 32'd7, 1'b0, 1'b0);
    step("reload", 1'b1, 1'b0, 32'h0000_0280, 32'h0, 1'b0, 1'b0);

    // Stall freezes everything while inputs change; flush wins over stall.
    step("stall_1", 1'b1, 1'b1, 32'h0, 32'd17, 1'b1, 1'b0);
    step("stall_2", 1'b0, 1'b0, 32'h0000_07C0, 32'd3, 1'b1, 1'b0);
    check("stall_2/val", shamt_q, 32'd10);
    step("flush_st", 1'b1, 1'b1, 32'h0, 32'd12, 1'b1, 1'b1);
    step("flush", 1'b1, 1'b1, 32'h0, 32'd0, 1'b0, 1'b1);
    step("resume", 1'b1, 1'b1, 32'h0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a valid 0x1F is held.
    step("pre_rst", 1'b1, 1'b1, 32'h0, 32'h1F, 1'b0, 1'b0);
    check("pre_rst/val", shamt_q, 32'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    model_reset();
    check("rst/comb", shamt, 32'h1F);
    #2;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b0, 1'b0);
    check("post_rst/val", shamt_q, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
